i_ddr_deser: RTL and testbench
==============================

# i_ddr_deser

Parametrised DDR input deserializer: per channel, captures `D` on both edges of `C` and assembles the bits into `2*RATIO`-bit parallel words. It adds a word-valid strobe and bit-granular word alignment (bitslip). It sits directly behind the input buffer or I_DELAY of each lane, in the same I/O tile position as a DDR input register. With `WIDTH=1, RATIO=1` and bitslip unused, `Q` carries the same pair of bits as a DDR input register, with `Q_VALID` added.

## Interface
Parameters:
- `WIDTH`, 1: number of independent input channels, 1..16.
- `RATIO`, 2: clock cycles per output word; each word is `2*RATIO` bits. Range 1..8.

Ports (one clock; reset is asynchronous and active-low):
- `C`  input  1  clock; `D` is sampled on both edges.
- `R`  input  1  active-low asynchronous reset.
- `E`  input  1  active-high enable for word assembly, output update and bitslip.
- `D`  input  WIDTH  serial data, one bit per channel.
- `BITSLIP`  input  1  sampled on enabled rising edges; shifts the word boundary by one bit, applied to all channels.
- `Q`  output  WIDTH*2*RATIO  parallel words; channel c is at `Q[c*2*RATIO +: 2*RATIO]`; the MSB of each word is the oldest bit.
- `Q_VALID`  output  1  one-cycle pulse marking a new word on `Q`.

## Operation
- **Capture.** Per channel, `pos` is loaded from `D` on each rising edge of `C` and `neg` on each falling edge. Capture ignores `E`. While `R` is low, both registers are forced to 0.
- **History.** Per channel there is a `4*RATIO`-bit shift register `hist`. On each rising edge with `E=1`: `hist <= {hist[4R-3:0], pos, neg}`. `pos` is the earlier bit of the pair.
- **Counter.** `cnt` runs 0..RATIO-1 and increments on each enabled rising edge. The edge where `cnt==RATIO-1` is a word boundary; `cnt` then wraps to 0.
- **Offset.** `off` runs 0..2*RATIO-1. Each enabled rising edge with `BITSLIP=1` sets `off <= (off+1) mod 2*RATIO`.
- **Output word.** At a word boundary, `Q` per channel is loaded with `h[2R-1+off : off]`, where `h` is `hist` after that edge's shift. The edge uses the `off` value from before any same-edge bitslip. `Q_VALID` is set to 1 on that edge; on every other rising edge it is set to 0.
- **E low.** `hist`, `cnt`, `off` and `Q` hold. `Q_VALID` is 0. `BITSLIP` is ignored.
- **RATIO=1.** Every enabled edge is a word boundary and `off` is 0..1.
- **Reset.** Asserting `R` low clears immediately: `Q=0`, `Q_VALID=0`, `cnt=0`, `off=0`, `hist=0`, `pos=neg=0`. After `R` rises, the first word boundary is the RATIO-th enabled rising edge. That first word contains the zeros loaded into `hist` at reset.

## Timing
- `D` sampled at rising edge k and at the following falling edge enters `hist` at rising edge k+1.
- Latency from `D` to `Q` is one rising edge of capture plus word assembly: the last pair of a word appears on `Q` at the boundary edge, together with `Q_VALID=1` for that cycle.
- A bitslip taken at edge t affects the first word boundary strictly after t. Each bitslip delays the window by one bit. 2*RATIO bitslips return to the original alignment.
- `Q_VALID` is never high for two consecutive cycles unless RATIO=1 and `E` stays high.
- Reset assertion is fully asynchronous; there is no partial word after reset.

## Structure
- Package `i_ddr_deser_pkg`:
  - `MAX_WIDTH=16`, `MAX_RATIO=8`.
  - Widths for `cnt` and `off`: `$clog2` of RATIO and of 2*RATIO, minimum 1.
  - Parameter range checks, performed at elaboration.
- Sub-module `i_ddr_cap` holds the per-channel dual-edge `pos`/`neg` capture with async clear. It is generated WIDTH times.
- `cnt`, `off` and `Q_VALID` are shared across channels in the top level. `hist` and the window mux are per channel.

## Test plan
- **Basic word, no slip.** WIDTH=1, RATIO=2, E=1. Drive D per half-cycle as the repeating pattern 1,0,1,1, aligned to `cnt=0` after reset. Required: `Q=4'b1011` with `Q_VALID` every 2nd edge; the first word after reset is 4'b0000 or partial per the reset rule.
- **Bitslip.** Same stream; pulse BITSLIP once. Required: next word 4'b1101. After 3 more pulses the word returns to 4'b1011. A pulse on a boundary edge changes the following word, not the current one.
- **Enable gating.** Hold E=0 for 3 cycles mid-word. Required: `Q` and `cnt` frozen, `Q_VALID=0`, BITSLIP ignored. Assembly resumes where it left off when E returns to 1.
- **Reset mid-word.** Assert R low asynchronously between edges. Required: all outputs 0 immediately. After release, the first `Q_VALID` comes on the 2nd enabled edge.
- **Multi-channel.** WIDTH=2, RATIO=4. Channel 0 gets alternating 1/0, channel 1 constant 1. Required: `Q[7:0]=8'hAA`, `Q[15:8]=8'hFF` every 4 enabled edges.
- **RATIO=1.** D=1 on rising, 0 on falling. Required: `Q=2'b10` with `Q_VALID` high every enabled cycle. One BITSLIP gives `Q=2'b01`.

Source files
------------

// File: rtl/i_ddr_deser_pkg.sv
// i_ddr_deser_pkg: shared limits and width helpers for the DDR input deserializer.
//   MAX_WIDTH / MAX_RATIO : legal upper bounds for the WIDTH and RATIO parameters.
//   clog2_min1            : $clog2 clamped to a minimum of 1 bit.
//   cnt_width / off_width : register widths for the word counter and bit offset.
//   params_ok             : elaboration-time legality check for WIDTH/RATIO.
package i_ddr_deser_pkg;

    localparam int unsigned MAX_WIDTH = 16;
    localparam int unsigned MAX_RATIO = 8;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // cnt counts 0..RATIO-1
    function automatic int unsigned cnt_width(input int unsigned ratio);
        return clog2_min1(ratio);
    endfunction

    // off counts 0..2*RATIO-1
    function automatic int unsigned off_width(input int unsigned ratio);
        return clog2_min1(2 * ratio);
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned ratio);
        return (width >= 1) && (width <= MAX_WIDTH) && (ratio >= 1) && (ratio <= MAX_RATIO);
    endfunction

endpackage

// File: rtl/i_ddr_cap.sv
// i_ddr_cap: dual-edge capture of one serial lane.
//   C   : clock; D is sampled on both edges.
//   R   : active-low asynchronous clear.
//   D   : serial data bit.
//   pos : D sampled on the rising edge of C (earlier bit of a pair).
//   neg : D sampled on the falling edge of C (later bit of a pair).
module i_ddr_cap (
    input  logic C,
    input  logic R,
    input  logic D,
    output logic pos,
    output logic neg
);

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            pos <= 1'b0;
        end else begin
            pos <= D;
        end
    end

    always_ff @(negedge C or negedge R) begin
        if (!R) begin
            neg <= 1'b0;
        end else begin
            neg <= D;
        end
    end

endmodule

// File: rtl/i_ddr_deser.sv
// i_ddr_deser: parametrised DDR input deserializer with word-valid strobe and bitslip.
//   C       : clock; D sampled on both edges.
//   R       : active-low asynchronous reset.
//   E       : enable for word assembly, output update and bitslip.
//   D       : WIDTH serial lanes.
//   BITSLIP : on an enabled rising edge, moves the word window one bit older (all lanes).
//   Q       : WIDTH words of 2*RATIO bits; lane c at Q[c*2*RATIO +: 2*RATIO], MSB oldest.
//   Q_VALID : one-cycle pulse when a new word is loaded onto Q.
module i_ddr_deser
    import i_ddr_deser_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned RATIO = 2
) (
    input  logic                     C,
    input  logic                     R,
    input  logic                     E,
    input  logic [WIDTH-1:0]         D,
    input  logic                     BITSLIP,
    output logic [WIDTH*2*RATIO-1:0] Q,
    output logic                     Q_VALID
);

    if (!params_ok(WIDTH, RATIO)) begin : g_param_err
        $error("i_ddr_deser: WIDTH must be 1..%0d and RATIO 1..%0d", MAX_WIDTH, MAX_RATIO);
    end

    localparam int unsigned WORD_W = 2 * RATIO;
    localparam int unsigned HIST_W = 4 * RATIO;
    localparam int unsigned CNT_W  = cnt_width(RATIO);
    localparam int unsigned OFF_W  = off_width(RATIO);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(WORD_W - 1);

    logic [WIDTH-1:0] pos;
    logic [WIDTH-1:0] neg;
    logic [CNT_W-1:0] cnt;
    logic [OFF_W-1:0] off;
    logic             boundary;

    assign boundary = E && (cnt == CNT_LAST);

    // Shared word counter, bit offset and valid strobe.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            cnt     <= '0;
            off     <= '0;
            Q_VALID <= 1'b0;
        end else begin
            Q_VALID <= boundary;
            if (E) begin
                cnt <= boundary ? '0 : cnt + 1'b1;
                if (BITSLIP) begin
                    off <= (off == OFF_LAST) ? '0 : off + 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < WIDTH; c++) begin : g_ch
        // The top pair of the 4*RATIO-bit history is shifted out without ever being inside
        // a window, so only the lower 4*RATIO-2 bits are stored.
        logic [HIST_W-3:0]  hist;
        logic [HIST_W-1:0]  hist_next;
        logic [WORD_W-1:0]  win;
        logic [WORD_W-1:0]  word;

        i_ddr_cap u_cap (
            .C   (C),
            .R   (R),
            .D   (D[c]),
            .pos (pos[c]),
            .neg (neg[c])
        );

        assign hist_next = {hist, pos[c], neg[c]};
        // Window uses the pre-bitslip offset of this edge.
        assign win       = WORD_W'(hist_next >> off);

        always_ff @(posedge C or negedge R) begin
            if (!R) begin
                hist <= '0;
                word <= '0;
            end else if (E) begin
                hist <= hist_next[HIST_W-3:0];
                if (cnt == CNT_LAST) begin
                    word <= win;
                end
            end
        end

        assign Q[c*WORD_W +: WORD_W] = word;
    end

endmodule

// File: tb/tb_i_ddr_deser.sv
// tb_i_ddr_deser: table-driven check of three i_ddr_deser configurations
// (WIDTH=1/RATIO=2, WIDTH=2/RATIO=4, WIDTH=1/RATIO=1) with a scoreboard of expected words.
module tb_i_ddr_deser;

    typedef struct {
        int unsigned sel;        // 0: u_a, 1: u_b, 2: u_c
        logic [1:0]  rise;       // D driven before the rising edge (bit per lane)
        logic [1:0]  fall;       // D driven before the following falling edge
        logic        e;
        logic        bs;
        logic        exp_valid;
        logic [15:0] exp_q;      // word expected when exp_valid
    } row_t;

    logic C = 1'b0;
    logic R = 1'b1;

    logic       e_a = 1'b0, bs_a = 1'b0;
    logic [0:0] d_a = '0;
    logic [3:0] q_a;
    logic       qv_a;

    logic       e_b = 1'b0, bs_b = 1'b0;
    logic [1:0] d_b = '0;
    logic [15:0] q_b;
    logic       qv_b;

    logic       e_c = 1'b0, bs_c = 1'b0;
    logic [0:0] d_c = '0;
    logic [1:0] q_c;
    logic       qv_c;

    always #5 C = ~C;

    i_ddr_deser #(.WIDTH(1), .RATIO(2)) u_a (
        .C(C), .R(R), .E(e_a), .D(d_a), .BITSLIP(bs_a), .Q(q_a), .Q_VALID(qv_a)
    );
    i_ddr_deser #(.WIDTH(2), .RATIO(4)) u_b (
        .C(C), .R(R), .E(e_b), .D(d_b), .BITSLIP(bs_b), .Q(q_b), .Q_VALID(qv_b)
    );
    i_ddr_deser #(.WIDTH(1), .RATIO(1)) u_c (
        .C(C), .R(R), .E(e_c), .D(d_c), .BITSLIP(bs_c), .Q(q_c), .Q_VALID(qv_c)
    );

    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    logic [15:0] sb[$];
    logic [15:0] hold = '0;
    row_t        tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic row_t mk(input int unsigned sel, input logic [1:0] rise,
                                input logic [1:0] fall, input logic e, input logic bs,
                                input logic v, input logic [15:0] q);
        row_t r;
        r.sel = sel; r.rise = rise; r.fall = fall; r.e = e; r.bs = bs;
        r.exp_valid = v; r.exp_q = q;
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        e_a = 1'b0; bs_a = 1'b0; d_a = '0;
        e_b = 1'b0; bs_b = 1'b0; d_b = '0;
        e_c = 1'b0; bs_c = 1'b0; d_c = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_q_a"},  {12'b0, q_a}, 16'h0);
        check({tag, "_qv_a"}, {15'b0, qv_a}, 16'h0);
        check({tag, "_q_b"},  q_b, 16'h0);
        check({tag, "_qv_b"}, {15'b0, qv_b}, 16'h0);
        check({tag, "_q_c"},  {14'b0, q_c}, 16'h0);
        check({tag, "_qv_c"}, {15'b0, qv_c}, 16'h0);
    endtask

    // Enters and leaves just after a falling edge.
    task automatic do_reset();
        idle_inputs();
        R = 1'b0;
        #1;
        check_all_zero("rst");
        @(posedge C); #1;
        @(negedge C); #1;
        R = 1'b1;
        sb.delete();
        hold = '0;
    endtask

    // Enters and leaves just after a falling edge.
    task automatic apply_row(input int idx, input row_t r);
        logic        act_v;
        logic [15:0] act_q;
        logic [15:0] exp;
        idle_inputs();
        case (r.sel)
            0: begin d_a = r.rise[0:0]; e_a = r.e; bs_a = r.bs; end
            1: begin d_b = r.rise;      e_b = r.e; bs_b = r.bs; end
            default: begin d_c = r.rise[0:0]; e_c = r.e; bs_c = r.bs; end
        endcase
        if (r.exp_valid) begin
            sb.push_back(r.exp_q);
            hold = r.exp_q;
        end
        @(posedge C); #1;
        case (r.sel)
            0: begin d_a = r.fall[0:0]; act_v = qv_a; act_q = {12'b0, q_a}; end
            1: begin d_b = r.fall;      act_v = qv_b; act_q = q_b; end
            default: begin d_c = r.fall[0:0]; act_v = qv_c; act_q = {14'b0, q_c}; end
        endcase
        check($sformatf("row%0d_valid", idx), {15'b0, act_v}, {15'b0, r.exp_valid});
        if (act_v) begin
            if (sb.size() == 0) begin
                mismatched++;
                compared++;
                $display("FAIL row%0d_word: got %h required no word", idx, act_q);
            end else begin
                exp = sb.pop_front();
                check($sformatf("row%0d_word", idx), act_q, exp);
            end
        end else begin
            if (r.exp_valid && sb.size() > 0) begin
                void'(sb.pop_front());
            end
            check($sformatf("row%0d_hold", idx), act_q, hold);
        end
        @(negedge C); #1;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            apply_row(i, tbl[i]);
        end
    endtask

    initial begin
        // u_a, WIDTH=1 RATIO=2: stream 1,0,1,1 per half-cycle, bitslip, enable gating.
        tbl.push_back(mk(0, 2'b01, 2'b01, 1, 0, 0, 16'h0));  // 0
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 0, 1, 16'h3));  // 1  first word 0011
        tbl.push_back(mk(0, 2'b01, 2'b01, 1, 0, 0, 16'h0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 0, 1, 16'hB));  // 1011
        tbl.push_back(mk(0, 2'b01, 2'b01, 1, 0, 0, 16'h0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 0, 1, 16'hB));  // 5
        tbl.push_back(mk(0, 2'b01, 2'b01, 1, 1, 0, 16'h0));  // slip off=1
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 0, 1, 16'hD));  // 1101
        tbl.push_back(mk(0, 2'b01, 2'b01, 1, 0, 0, 16'h0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 1, 1, 16'hD));  // slip on boundary: still 1101
        tbl.push_back(mk(0, 2'b01, 2'b01, 1, 1, 0, 16'h0));  // 10 off=3
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 0, 1, 16'h7));  // 0111
        tbl.push_back(mk(0, 2'b01, 2'b01, 1, 1, 0, 16'h0));  // off wraps to 0
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 0, 1, 16'hB));  // back to 1011
        tbl.push_back(mk(0, 2'b01, 2'b01, 1, 0, 0, 16'h0));  // mid-word
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 0, 16'h0));  // 15 E low, slip ignored
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 0, 16'h0));
        tbl.push_back(mk(0, 2'b01, 2'b01, 0, 1, 0, 16'h0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 0, 1, 16'hB));  // resumes: 10 + 11
        tbl.push_back(mk(0, 2'b01, 2'b01, 1, 0, 0, 16'h0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 0, 1, 16'hB));  // 20
        tbl.push_back(mk(0, 2'b01, 2'b01, 1, 0, 0, 16'h0));  // 21 mid-word before reset
        tbl.push_back(mk(0, 2'b01, 2'b01, 1, 0, 0, 16'h0));  // 22 after reset
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 0, 1, 16'h3));  // 2nd enabled edge: 0011
        tbl.push_back(mk(0, 2'b01, 2'b01, 1, 0, 0, 16'h0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 0, 1, 16'hB));  // 25
        // u_b, WIDTH=2 RATIO=4: lane 0 alternating 1/0, lane 1 constant 1.
        for (int i = 0; i < 16; i++) begin
            logic [15:0] w;
            w = 16'h0;
            if (i == 3)  w = 16'h3F2A;
            if (i == 7)  w = 16'hFFAA;
            if (i == 11) w = 16'hFFAA;
            if (i == 15) w = 16'hFF55;
            tbl.push_back(mk(1, 2'b11, 2'b10, 1, (i == 12), ((i % 4) == 3), w));  // 26..41
        end
        // u_c, WIDTH=1 RATIO=1: rise 1, fall 0.
        tbl.push_back(mk(2, 2'b01, 2'b00, 1, 0, 1, 16'h0));  // 42 reset zeros
        tbl.push_back(mk(2, 2'b01, 2'b00, 1, 0, 1, 16'h2));
        tbl.push_back(mk(2, 2'b01, 2'b00, 1, 0, 1, 16'h2));
        tbl.push_back(mk(2, 2'b01, 2'b00, 1, 1, 1, 16'h2));  // slip takes effect next word
        tbl.push_back(mk(2, 2'b01, 2'b00, 1, 0, 1, 16'h1));
        tbl.push_back(mk(2, 2'b01, 2'b00, 1, 0, 1, 16'h1));
        tbl.push_back(mk(2, 2'b01, 2'b00, 0, 1, 0, 16'h0));  // E low, slip ignored
        tbl.push_back(mk(2, 2'b01, 2'b00, 1, 0, 1, 16'h1));
        tbl.push_back(mk(2, 2'b01, 2'b00, 1, 1, 1, 16'h1));
        tbl.push_back(mk(2, 2'b01, 2'b00, 1, 0, 1, 16'h2));  // 51

        #2;
        do_reset();
        run_rows(0, 22);

        // Asynchronous reset between edges, mid-word.
        check("pre_rst_q_a", {12'b0, q_a}, 16'hB);
        #1;
        R = 1'b0;
        #1;
        check("async_rst_q_a",  {12'b0, q_a}, 16'h0);
        check("async_rst_qv_a", {15'b0, qv_a}, 16'h0);
        @(posedge C); #1;
        check("held_rst_q_a", {12'b0, q_a}, 16'h0);
        @(negedge C); #1;
        R = 1'b1;
        sb.delete();
        hold = '0;
        run_rows(22, 26);

        do_reset();
        run_rows(26, 42);

        do_reset();
        run_rows(42, 52);

        check("sb_empty", 16'(sb.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
